// File: rtl/exponent_bias_restorer.sv
// Exponent bias restorer: re-applies the single-precision exponent bias to an
// unbiased result exponent, range-checks it and packs a 32-bit IEEE-754 word.
// Two-stage valid/ready pipeline: s1 computes the biased exponent, s2 classifies
// the beat and holds the packed result until downstream accepts it.
module exponent_bias_restorer #(
  parameter int BIAS  = 127,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             add_bias,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exponent,
  input  logic [23:0]      in_mantissa,
  input  logic             in_nan,
  input  logic             in_inf,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow
);

  // One extra bit over the input exponent so adding the bias can never wrap.
  localparam int BW = EXP_W + 1;
  localparam logic signed [BW-1:0] BIAS_V  = BW'(BIAS);
  localparam logic signed [BW-1:0] EXP_MAX = BW'(255);
  localparam logic signed [BW-1:0] EXP_MIN = '0;

  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_nan;
  logic                 s1_inf;
  logic                 s1_zero;
  logic [23:0]          s1_mant;
  logic signed [BW-1:0] s1_biased;

  logic                 s2_valid;
  logic [31:0]          result_reg;
  logic                 overflow_reg;
  logic                 underflow_reg;

  logic                 s1_load;
  logic                 s2_load;
  logic signed [BW-1:0] in_ext;
  logic signed [BW-1:0] bias_term;
  logic signed [BW-1:0] biased_next;
  logic [31:0]          result_next;
  logic                 overflow_next;
  logic                 underflow_next;

  // s1 may accept whenever it is empty, or its beat will move on this cycle.
  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!s2_valid || out_ready);

  assign in_ext      = {in_exponent[EXP_W-1], in_exponent};
  assign bias_term   = add_bias ? BIAS_V : '0;
  assign biased_next = in_ext + bias_term;

  assign out_valid     = s2_valid;
  assign out_result    = result_reg;
  assign out_overflow  = overflow_reg;
  assign out_underflow = underflow_reg;

  // Stage 1: capture the beat with its exponent already biased.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_mant   <= '0;
      s1_biased <= '0;
    end else begin
      if (s1_load) begin
        s1_valid  <= 1'b1;
        s1_sign   <= in_sign;
        s1_nan    <= in_nan;
        s1_inf    <= in_inf;
        s1_zero   <= in_zero;
        s1_mant   <= in_mantissa;
        s1_biased <= biased_next;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Classification of the s1 beat; special operands take priority over range checks.
  always_comb begin
    result_next    = {s1_sign, s1_biased[7:0], s1_mant[22:0]};
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (s1_nan) begin
      result_next = 32'h7FC0_0000;
    end else if (s1_inf) begin
      result_next = {s1_sign, 8'hFF, 23'h0};
    end else if (s1_zero || !s1_mant[23]) begin
      result_next = {s1_sign, 31'h0};
    end else if (s1_biased >= EXP_MAX) begin
      result_next   = {s1_sign, 8'hFF, 23'h0};
      overflow_next = 1'b1;
    end else if (s1_biased <= EXP_MIN) begin
      result_next    = {s1_sign, 31'h0};
      underflow_next = 1'b1;
    end
  end

  // Stage 2: hold the packed result until it is taken; refill in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid      <= 1'b0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid      <= 1'b1;
        result_reg    <= result_next;
        overflow_reg  <= overflow_next;
        underflow_reg <= underflow_next;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exponent_bias_restorer.sv
// Scoreboard bench for exponent_bias_restorer: the driver pushes hand-computed
// results as beats are accepted, an independent monitor pops and compares.
module tb_exponent_bias_restorer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        add_bias;
  logic        in_sign;
  logic [9:0]  in_exponent;
  logic [23:0] in_mantissa;
  logic        in_nan;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   fails    = 0;
  int   inflight = 0;
  int   beat_no  = 0;

  exponent_bias_restorer #(.BIAS(127), .EXP_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .add_bias     (add_bias),
    .in_sign      (in_sign),
    .in_exponent  (in_exponent),
    .in_mantissa  (in_mantissa),
    .in_nan       (in_nan),
    .in_inf       (in_inf),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one beat; push its expected result when the transfer is certain.
  task automatic send(input logic ab, input logic sg, input int e, input logic [23:0] m,
                      input logic nn, input logic nf, input logic zr,
                      input logic [31:0] er, input logic eo, input logic eu);
    int   e_v;
    exp_t x;
    bit   done;
    e_v         = e;
    add_bias    = ab;
    in_sign     = sg;
    in_exponent = e_v[9:0];
    in_mantissa = m;
    in_nan      = nn;
    in_inf      = nf;
    in_zero     = zr;
    in_valid    = 1'b1;
    done        = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        x.res = er;
        x.ovf = eo;
        x.unf = eu;
        sb.push_back(x);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    check("drain_empty", 34'(sb.size()), 34'd0);
  endtask

  // Monitor: handshake model, ordered pop/compare, stall stability.
  initial begin
    exp_t       x;
    logic [33:0] held_val;
    bit          held;
    bit          exp_ir;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        exp_ir = (inflight < 2) || out_ready;
        check("in_ready", {33'd0, in_ready}, {33'd0, exp_ir});
        if (out_valid) begin
          if (held) check("stall_stable", {out_result, out_overflow, out_underflow}, held_val);
          if (out_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL unexpected_output: got %h, expected no output", out_result);
            end else begin
              x = sb.pop_front();
              beat_no++;
              check("out_beat", {out_result, out_overflow, out_underflow}, {x.res, x.ovf, x.unf});
              $display("beat %0d: result=%h ovf=%b unf=%b (expected %h %b %b)",
                       beat_no, out_result, out_overflow, out_underflow, x.res, x.ovf, x.unf);
            end
          end else begin
            held     = 1'b1;
            held_val = {out_result, out_overflow, out_underflow};
          end
        end else begin
          held = 1'b0;
        end
        if (in_valid && in_ready) inflight++;
        if (out_valid && out_ready) inflight--;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; add_bias = 1'b0; in_sign = 1'b0;
    in_exponent = '0; in_mantissa = '0; in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
    #2;
    check("reset_state", {out_valid, out_result, out_overflow, out_underflow}, 35'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {33'd0, in_ready}, 34'd1);
    @(posedge clk); #1;

    // 1: basic packing and latency.
    send(1, 0, 0, 24'h800000, 0, 0, 0, 32'h3F80_0000, 0, 0);
    @(negedge clk);
    check("latency_s1", {33'd0, out_valid}, 34'd0);
    @(negedge clk);
    check("latency_s2", {33'd0, out_valid}, 34'd1);
    @(posedge clk); #1;
    send(1, 0, 127, 24'hFFFFFF, 0, 0, 0, 32'h7F7F_FFFF, 0, 0);

    // 2: overflow boundary, mixed add_bias back to back.
    send(1, 1, 128, 24'h800000, 0, 0, 0, 32'hFF80_0000, 1, 0);
    send(0, 0, 254, 24'h800000, 0, 0, 0, 32'h7F00_0000, 0, 0);
    send(0, 0, 255, 24'h800000, 0, 0, 0, 32'h7F80_0000, 1, 0);

    // 3: underflow boundary and extreme negative exponent.
    send(1, 1, -127, 24'h800000, 0, 0, 0, 32'h8000_0000, 0, 1);
    send(1, 0, -126, 24'h800000, 0, 0, 0, 32'h0080_0000, 0, 0);
    send(1, 0, -512, 24'h800000, 0, 0, 0, 32'h0000_0000, 0, 1);

    // 4: special operand priority, hidden bit clear.
    send(1, 1, 200, 24'h800000, 1, 1, 0, 32'h7FC0_0000, 0, 0);
    send(1, 1, 5, 24'h800000, 0, 1, 1, 32'hFF80_0000, 0, 0);
    send(1, 1, 5, 24'h400000, 0, 0, 0, 32'h8000_0000, 0, 0);
    drain();

    // 5: streaming with downstream stall.
    @(posedge clk); #1;
    fork
      begin
        send(1, 0, 0, 24'h800000, 0, 0, 0, 32'h3F80_0000, 0, 0);
        send(1, 0, 1, 24'h800000, 0, 0, 0, 32'h4000_0000, 0, 0);
        send(1, 0, 2, 24'h800000, 0, 0, 0, 32'h4080_0000, 0, 0);
        send(1, 0, 3, 24'h800000, 0, 0, 0, 32'h4100_0000, 0, 0);
        send(1, 0, 4, 24'h800000, 0, 0, 0, 32'h4180_0000, 0, 0);
        send(1, 0, 5, 24'h800000, 0, 0, 0, 32'h4200_0000, 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // 6: asynchronous reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1, 0, 2, 24'h800000, 0, 0, 0, 32'h4080_0000, 0, 0);
    send(1, 0, 3, 24'h800000, 0, 0, 0, 32'h4100_0000, 0, 0);
    @(negedge clk);
    check("full_before_reset", {33'd0, out_valid}, 34'd1);
    #2 reset = 1'b1;
    sb.delete();
    inflight = 0;
    #1;
    check("async_reset", {out_valid, out_result, out_overflow, out_underflow}, 35'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(1, 0, 1, 24'hC00000, 0, 0, 0, 32'h4040_0000, 0, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_output", {33'd0, out_valid}, 34'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/exponent_bias_restorer.md
Name: exponent_bias_restorer

Overview:
Return-path counterpart to operand bias removal. Takes a sign, a signed unbiased result exponent and a normalized 24-bit mantissa from the FPU datapath. Re-applies the IEEE-754 single-precision bias of 127, range-checks the result and packs a 32-bit word. It is a 2-stage valid/ready pipeline sitting between the arithmetic core and the result writeback.

Parameters:
BIAS, 127, exponent bias added when add_bias=1
EXP_W, 10, width of signed unbiased input exponent (two's complement)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input this cycle
add_bias  input  1  1: add BIAS to in_exponent; 0: in_exponent is already biased
in_sign  input  1  result sign
in_exponent  input  EXP_W  signed exponent
in_mantissa  input  24  mantissa, bit 23 = hidden bit
in_nan  input  1  force canonical NaN
in_inf  input  1  force signed infinity
in_zero  input  1  force signed zero
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  32  packed single-precision word
out_overflow  output  1  exponent overflowed to infinity
out_underflow  output  1  exponent underflowed, flushed to zero

Behaviour:
- Handshake: a transfer occurs when valid && ready, on both ports.
- Stage 1 (s1) registers sign, mantissa and flags, plus biased = sext(in_exponent, EXP_W+1) + (add_bias ? BIAS : 0). Width is EXP_W+1 so it cannot wrap.
- Stage 2 (s2) classifies and registers out_result and the flags.
- Advance rules:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational).
- Throughput is 1 beat/cycle. Latency is 2 cycles from input transfer to out_valid when unstalled.
- out_valid = s2_valid.
- When out_valid && !out_ready, out_result and the flags hold stable and order is preserved. No beat may be dropped or duplicated.
- Classification priority (first match wins):
  1. in_nan: 0x7FC00000 (sign ignored), flags 0.
  2. in_inf: {sign, 8'hFF, 23'h0}, flags 0.
  3. in_zero, or mantissa[23]==0: {sign, 31'h0}, flags 0.
  4. biased >= 255: {sign, 8'hFF, 23'h0}, out_overflow=1.
  5. biased <= 0: {sign, 31'h0}, out_underflow=1. Denormals are not produced.
  6. Otherwise: {sign, biased[7:0], mantissa[22:0]}.
- Overflow and underflow are mutually exclusive and are valid only while out_valid=1.
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_overflow=0, out_underflow=0. in_ready=1 while reset is deasserted and the pipe is empty.
- Reset mid-operation discards in-flight beats. No partial output appears after reset release.
- Simultaneous output transfer and s1->s2 move in the same cycle is legal: s2 is replaced, with no bubble.
- add_bias is sampled per beat with that beat's data. Mixing add_bias values in consecutive beats is legal.

Test Plan:
1. add_bias=1, sign=0, exp=0, mant=0x800000, out_ready=1 -> 2 cycles later out_result=0x3F800000, flags 0. Then exp=127, mant=0xFFFFFF -> 0x7F7FFFFF.
2. add_bias=1, exp=128 (biased 255), sign=1 -> 0xFF800000, out_overflow=1. Also add_bias=0, exp=254 -> exponent field 0xFE, no overflow.
3. add_bias=1, sign=1, exp=-127 -> 0x80000000, out_underflow=1. Then exp=-126, sign=0, mant=0x800000 -> 0x00800000, underflow=0. Then exp=-512 -> underflow=1, no wrap.
4. in_nan=1 with exp=200 and in_inf=1 -> 0x7FC00000, flags 0. in_inf=1 with in_zero=1, sign=1 -> 0xFF800000.
5. Stream 6 back-to-back beats with exp 0..5 while out_ready is low for cycles 3-6:
   - in_ready=0 exactly while both stages are full and out_ready=0.
   - Outputs are 0x3F800000, 0x40000000, 0x40800000, ... in order, each appearing once.
   - out_result is stable while stalled.
6. Assert reset asynchronously (mid-cycle) with s1 and s2 valid and out_ready=0 -> out_valid=0 immediately. After release, send exp=1, mant=0xC00000 -> single output 0x40400000.
